tinyalu_op_driver: RTL and testbench
====================================

TINYALU_OP_DRIVER -- requirements
Module: tinyalu_op_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the input operation queue depth in entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32, giving the maximum cycles alu_start stays high awaiting alu_done.
REQ-003 SHALL have port clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  upstream operation valid.
REQ-006 SHALL have port op_ready  output  1  queue can accept an operation.
REQ-007 SHALL have ports op_A, op_B  input  8 each  operands.
REQ-008 SHALL have port op_code  input  3  no_op=0, add=1, and=2, xor=3, mul=4.
REQ-009 SHALL have ports alu_A, alu_B  output  8 each, and alu_op  output  3; these drive the TinyALU.
REQ-010 SHALL have port alu_start  output  1  TinyALU start.
REQ-011 SHALL have port alu_done  input  1, and alu_result  input  16; both come from the TinyALU.
REQ-012 SHALL have port res_valid  output  1, and res_ready  input  1; these form the result handshake.
REQ-013 SHALL have ports res_data  output  16, res_op  output  3, and res_timeout  output  1.
REQ-014 SHALL have port ops_done  output  16  count of completed result handshakes.

Function
REQ-015 SHALL accept an operation on a posedge with op_valid && op_ready, copying op_A/op_B/op_code into the queue by value; later input changes SHALL NOT alter queued entries.
REQ-016 SHALL drive op_ready = !full, registered; a simultaneous push and pop when full SHALL NOT be accepted (no bypass).
REQ-017 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-018 IDLE with queue non-empty SHALL pop the head on that edge, load alu_A/alu_B/alu_op, and go to BUSY with alu_start=1 from the next cycle. alu_start therefore rises one cycle after the write into an empty queue.
REQ-019 IDLE with head op_code 0 or 5..7 SHALL pop the entry, keep alu_start=0, and go to HOLD with res_data=0, res_op=head code, res_timeout=0.
REQ-020 BUSY SHALL hold alu_start=1 and stable alu_A/alu_B/alu_op until alu_done is sampled 1.
REQ-021 BUSY on alu_done=1 SHALL capture alu_result into res_data, set res_op=alu_op and res_timeout=0, clear alu_start, and go to HOLD with res_valid=1 the next cycle.
REQ-022 BUSY SHALL count cycles from 1. If the count reaches TIMEOUT_CYCLES without alu_done, it SHALL clear alu_start, set res_data=0 and res_timeout=1, and go to HOLD.
REQ-023 If alu_done and timeout expiry occur on the same cycle, alu_done SHALL win (res_timeout=0).
REQ-024 HOLD SHALL keep res_valid=1 and res_* stable until res_ready=1, then go to IDLE. alu_start is thus low for >=1 cycle between operations.
REQ-025 alu_done sampled 1 outside BUSY SHALL be ignored.
REQ-026 ops_done SHALL increment on each res_valid && res_ready edge and wrap 16'hFFFF->0.
REQ-027 The queue SHALL accept pushes in every state, including BUSY and HOLD.

Reset
REQ-028 reset=1 on a posedge SHALL force state IDLE, empty the queue, and zero all outputs except op_ready. op_ready SHALL be 1 the first cycle after reset deasserts.
REQ-029 Reset during BUSY or HOLD SHALL drop alu_start and res_valid on that edge and discard all queued and in-flight operations without producing a result.

Verification
REQ-030 Add: push (FF,55,add), alu_done 1 cycle after start, alu_result=0x0154 -> res_valid with res_data=0x0154, res_op=1, res_timeout=0, ops_done=1.
REQ-031 Xor then mul back-to-back: push (AA,EE,xor) then (FF,FF,mul), mul done 3 cycles after start -> results 0x0044 then 0xFE01 in order, with alu_start low >=1 cycle between them.
REQ-032 Back-pressure: res_ready=0, push 6 ops with DEPTH=4 -> 5 accepted (1 in flight, 4 queued) and op_ready=0 on the 6th; releasing res_ready drains all 5 in order.
REQ-033 Timeout: push (01,02,add), never assert alu_done -> alu_start high exactly 32 cycles, then res_valid=1, res_timeout=1, res_data=0.
REQ-034 no_op/invalid: push (12,34,no_op) and (12,34,code 6) -> alu_start stays 0 and two results with res_data=0 are produced.
REQ-035 Reset mid-mul: assert reset while alu_start=1 with 2 queued -> alu_start=0, res_valid=0, op_ready=1, ops_done=0, and no later result emerges.

Source files
------------

// File: rtl/tinyalu_op_driver.sv
// tinyalu_op_driver
//
// Queues operations from an upstream valid/ready source and issues them one at
// a time to a TinyALU, then presents each result on a valid/ready result port.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both 1.
// The source keeps its payload stable while valid is high and ready is low.
// The sink may hold ready low for any number of cycles.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   op_valid/op_ready      operation input handshake (op_ready = !full, registered)
//   op_A, op_B, op_code    operation payload (0 no_op, 1 add, 2 and, 3 xor, 4 mul)
//   alu_A, alu_B, alu_op   operands and opcode driven to the TinyALU
//   alu_start              held high while waiting for the TinyALU
//   alu_done, alu_result   completion strobe and result from the TinyALU
//   res_valid/res_ready    result output handshake
//   res_data, res_op       result value and the opcode that produced it
//   res_timeout            result was produced by the timeout, not by alu_done
//   ops_done               count of completed result handshakes (wraps)
//   fsm_state              current FSM state (0 IDLE, 1 BUSY, 2 HOLD), for debug
module tinyalu_op_driver #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_A,
    input  logic [7:0]  op_B,
    input  logic [2:0]  op_code,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [2:0]  res_op,
    output logic        res_timeout,
    output logic [15:0] ops_done,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_n;

    // ---------------------------------------------------------------- queue
    logic [7:0]    q_a    [DEPTH];
    logic [7:0]    q_b    [DEPTH];
    logic [2:0]    q_code [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          push, pop;
    logic [7:0]    head_a, head_b;
    logic [2:0]    head_code;

    // op_ready is the registered !full, so a push while full is never taken,
    // even when the FSM pops on the same edge.
    assign push      = op_valid && op_ready;
    assign head_a    = q_a[rd_ptr];
    assign head_b    = q_b[rd_ptr];
    assign head_code = q_code[rd_ptr];

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (!push && pop) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_a[wr_ptr]    <= op_A;
            q_b[wr_ptr]    <= op_B;
            q_code[wr_ptr] <= op_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            op_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_n;
            op_ready <= (count_n != FULL_COUNT);
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [7:0]    alu_A_n, alu_B_n;
    logic [2:0]    alu_op_n, res_op_n;
    logic          alu_start_n, res_valid_n, res_timeout_n;
    logic [15:0]   res_data_n, ops_done_n;
    logic [TW-1:0] timer, timer_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_op      <= '0;
            res_timeout <= 1'b0;
            ops_done    <= '0;
            timer       <= '0;
        end else begin
            state       <= state_n;
            alu_A       <= alu_A_n;
            alu_B       <= alu_B_n;
            alu_op      <= alu_op_n;
            alu_start   <= alu_start_n;
            res_valid   <= res_valid_n;
            res_data    <= res_data_n;
            res_op      <= res_op_n;
            res_timeout <= res_timeout_n;
            ops_done    <= ops_done_n;
            timer       <= timer_n;
        end
    end

    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        alu_A_n       = alu_A;
        alu_B_n       = alu_B;
        alu_op_n      = alu_op;
        alu_start_n   = alu_start;
        res_valid_n   = res_valid;
        res_data_n    = res_data;
        res_op_n      = res_op;
        res_timeout_n = res_timeout;
        ops_done_n    = ops_done;
        timer_n       = timer;

        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_code >= 3'd1 && head_code <= 3'd4) begin
                        alu_A_n     = head_a;
                        alu_B_n     = head_b;
                        alu_op_n    = head_code;
                        alu_start_n = 1'b1;
                        timer_n     = TW'(1);  // first BUSY cycle is cycle 1
                        state_n     = BUSY;
                    end else begin
                        // no_op and undefined codes never reach the ALU
                        res_valid_n   = 1'b1;
                        res_data_n    = '0;
                        res_op_n      = head_code;
                        res_timeout_n = 1'b0;
                        state_n       = HOLD;
                    end
                end
            end
            BUSY: begin
                // alu_done is checked first so it wins over a same-cycle timeout
                if (alu_done) begin
                    alu_start_n   = 1'b0;
                    res_valid_n   = 1'b1;
                    res_data_n    = alu_result;
                    res_op_n      = alu_op;
                    res_timeout_n = 1'b0;
                    state_n       = HOLD;
                end else if (timer == TIMER_MAX) begin
                    alu_start_n   = 1'b0;
                    res_valid_n   = 1'b1;
                    res_data_n    = '0;
                    res_op_n      = alu_op;
                    res_timeout_n = 1'b1;
                    state_n       = HOLD;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    ops_done_n  = ops_done + 16'd1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_tinyalu_op_driver.sv
// Directed testbench for tinyalu_op_driver (DEPTH=4, TIMEOUT_CYCLES=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_tinyalu_op_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_A, op_B;
    logic [2:0]  op_code;
    logic [7:0]  alu_A, alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        res_timeout;
    logic [15:0] ops_done;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;
    int exp_ops = 0;

    tinyalu_op_driver #(.DEPTH(4), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_A(op_A), .op_B(op_B), .op_code(op_code),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_timeout(res_timeout),
        .ops_done(ops_done), .fsm_state(fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                        output bit accepted);
        op_A = a; op_B = b; op_code = c; op_valid = 1'b1;
        accepted = op_ready;
        tick();
        op_valid = 1'b0;
    endtask

    // Waits for alu_start, checks operands, then returns alu_done after `delay`
    // cycles of start (delay=1: done sampled on the first edge after start).
    task automatic run_alu(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [2:0] eop, input logic [15:0] result, input int delay);
        int n = 0;
        while (!alu_start && n < 50) begin tick(); n++; end
        chk({tag, "_start"}, alu_start, 1);
        chk({tag, "_alu_A"}, alu_A, ea);
        chk({tag, "_alu_B"}, alu_B, eb);
        chk({tag, "_alu_op"}, alu_op, eop);
        if (delay > 1) begin
            repeat (delay - 1) tick();
            chk({tag, "_start_held"}, alu_start, 1);
            chk({tag, "_alu_A_held"}, alu_A, ea);
        end
        alu_result = result;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        alu_result = 16'h0;
    endtask

    // Waits for a result, checks it, and completes the handshake.
    task automatic take_res(input string tag, input logic [15:0] ed, input logic [2:0] eop,
                            input logic eto);
        int n = 0;
        while (!res_valid && n < 60) begin tick(); n++; end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_data"}, res_data, ed);
        chk({tag, "_op"}, res_op, eop);
        chk({tag, "_timeout"}, res_timeout, eto);
        chk({tag, "_start_low"}, alu_start, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_ops++;
        chk({tag, "_ops_done"}, ops_done, exp_ops);
        chk({tag, "_valid_drop"}, res_valid, 0);
        chk({tag, "_start_gap"}, alu_start, 0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int n_high;
        int guard;
        int stray;

        reset = 1'b1; op_valid = 1'b0; op_A = 8'h0; op_B = 8'h0; op_code = 3'd0;
        alu_done = 1'b0; alu_result = 16'h0; res_ready = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_op_ready", op_ready, 1);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_outputs", {alu_A, alu_B, alu_op, res_data, res_op, res_timeout}, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_state", fsm_state, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_op_ready", op_ready, 1);

        // add: start rises one cycle after the write into the empty queue
        push(8'hFF, 8'h55, 3'd1, acc);
        chk("add_accept", acc, 1);
        chk("add_start_latency0", alu_start, 0);
        tick();
        chk("add_start_latency1", alu_start, 1);
        run_alu("add", 8'hFF, 8'h55, 3'd1, 16'h0154, 1);
        take_res("add", 16'h0154, 3'd1, 1'b0);

        // alu_done outside BUSY is ignored
        alu_result = 16'hBEEF; alu_done = 1'b1;
        tick();
        alu_done = 1'b0; alu_result = 16'h0;
        tick();
        chk("stray_done_valid", res_valid, 0);
        chk("stray_done_state", fsm_state, 0);

        // xor then mul back-to-back
        push(8'hAA, 8'hEE, 3'd3, acc);
        push(8'hFF, 8'hFF, 3'd4, acc);
        run_alu("xor", 8'hAA, 8'hEE, 3'd3, 16'h0044, 1);
        take_res("xor", 16'h0044, 3'd3, 1'b0);
        run_alu("mul", 8'hFF, 8'hFF, 3'd4, 16'hFE01, 3);
        take_res("mul", 16'hFE01, 3'd4, 1'b0);

        // back-pressure: 6 pushes, 5 accepted; operands change every cycle
        n_acc = 0;
        push(8'h01, 8'h01, 3'd1, acc); n_acc += int'(acc);
        push(8'h02, 8'h03, 3'd2, acc); n_acc += int'(acc);
        push(8'h03, 8'h05, 3'd3, acc); n_acc += int'(acc);
        push(8'h04, 8'h04, 3'd4, acc); n_acc += int'(acc);
        push(8'h05, 8'h06, 3'd1, acc); n_acc += int'(acc);
        chk("bp_full_op_ready", op_ready, 0);
        push(8'h07, 8'h07, 3'd1, acc); n_acc += int'(acc);
        chk("bp_sixth_rejected", acc, 0);
        chk("bp_accepted", n_acc, 5);
        run_alu("bp0", 8'h01, 8'h01, 3'd1, 16'h0002, 1);
        repeat (3) tick();
        chk("bp0_hold_valid", res_valid, 1);
        chk("bp0_hold_data", res_data, 16'h0002);
        take_res("bp0", 16'h0002, 3'd1, 1'b0);
        run_alu("bp1", 8'h02, 8'h03, 3'd2, 16'h0002, 1);
        take_res("bp1", 16'h0002, 3'd2, 1'b0);
        run_alu("bp2", 8'h03, 8'h05, 3'd3, 16'h0006, 2);
        take_res("bp2", 16'h0006, 3'd3, 1'b0);
        run_alu("bp3", 8'h04, 8'h04, 3'd4, 16'h0010, 1);
        take_res("bp3", 16'h0010, 3'd4, 1'b0);
        run_alu("bp4", 8'h05, 8'h06, 3'd1, 16'h000B, 1);
        take_res("bp4", 16'h000B, 3'd1, 1'b0);
        repeat (3) tick();
        chk("bp_drained_state", fsm_state, 0);
        chk("bp_drained_start", alu_start, 0);

        // timeout: alu_start high exactly 32 cycles
        push(8'h01, 8'h02, 3'd1, acc);
        guard = 0;
        while (!alu_start && guard < 10) begin tick(); guard++; end
        n_high = 0;
        guard = 0;
        while (alu_start && guard < 100) begin n_high++; tick(); guard++; end
        chk("to_start_cycles", n_high, 32);
        take_res("to", 16'h0000, 3'd1, 1'b1);

        // done on the final timeout cycle wins
        push(8'h09, 8'h03, 3'd2, acc);
        run_alu("to_race", 8'h09, 8'h03, 3'd2, 16'h0001, 32);
        take_res("to_race", 16'h0001, 3'd2, 1'b0);

        // no_op and invalid code bypass the ALU
        push(8'h12, 8'h34, 3'd0, acc);
        push(8'h12, 8'h34, 3'd6, acc);
        chk("noop_start", alu_start, 0);
        take_res("noop", 16'h0000, 3'd0, 1'b0);
        take_res("inval", 16'h0000, 3'd6, 1'b0);

        // reset mid-mul with two queued entries
        push(8'h03, 8'h04, 3'd4, acc);
        push(8'h05, 8'h06, 3'd1, acc);
        push(8'h07, 8'h08, 3'd2, acc);
        chk("mrst_start_before", alu_start, 1);
        reset = 1'b1;
        tick();
        chk("mrst_start", alu_start, 0);
        chk("mrst_valid", res_valid, 0);
        chk("mrst_op_ready", op_ready, 1);
        chk("mrst_ops_done", ops_done, 0);
        reset = 1'b0;
        tick();
        chk("mrst_op_ready_after", op_ready, 1);
        chk("mrst_state", fsm_state, 0);
        stray = 0;
        repeat (40) begin
            if (alu_start || res_valid) stray++;
            tick();
        end
        chk("mrst_no_result", stray, 0);
        chk("mrst_ops_done_after", ops_done, 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
